// File: rtl/lfsr_sng.sv
// lfsr_sng: parametrised Fibonacci LFSR with seed reload, zero-state recovery,
// period measurement and an optional unipolar stochastic number generator.
// Optional comparator stage is enabled by defining the macro LFSR_SNG_EN.
module lfsr_sng #(
  parameter int unsigned    W          = 4,
  parameter logic [W-1:0]   TAPS       = W'(4'b1100),
  parameter logic [W-1:0]   RESET_SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] thr,
  output logic [W-1:0] state,
  output logic         q,
  output logic         wrap,
  output logic [W-1:0] period,
  output logic         lockup,
  output logic         sbit
);

  logic [W-1:0] seed_reg;
  logic [W-1:0] cnt;
  logic [W-1:0] next_state;
  logic         fb;

  // Feedback is the parity of the tapped state bits; shift it in at the LSB.
  assign fb         = ^(state & TAPS);
  assign q          = fb;
  assign next_state = {state[W-2:0], fb};

  // LFSR state, seed copy, step counter and wrap/period/lock-up tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_SEED;
      seed_reg <= RESET_SEED;
      cnt      <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      lockup   <= 1'b0;
    end else if (load) begin
      state    <= seed;
      seed_reg <= seed;
      cnt      <= '0;
      wrap     <= 1'b0;
      lockup   <= 1'b0;
    end else if (en) begin
      if (state == '0) begin
        // All-zero state never leaves on its own; kick it to 1 and flag it.
        state  <= W'(1);
        lockup <= 1'b1;
        cnt    <= '0;
        wrap   <= 1'b0;
      end else begin
        state <= next_state;
        if (next_state == seed_reg) begin
          wrap   <= 1'b1;
          period <= cnt + W'(1);
          cnt    <= '0;
        end else begin
          wrap   <= 1'b0;
          cnt    <= cnt + W'(1);
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef LFSR_SNG_EN
  // Unipolar SNG: compare registered state against the threshold every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbit <= 1'b0;
    end else begin
      sbit <= (state < thr);
    end
  end
`else
  // Comparator absent: the stochastic bit is constant zero.
  logic unused_thr;
  assign unused_thr = ^thr;
  assign sbit       = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sng.sv
// tb_lfsr_sng: table-driven and randomized checks of lfsr_sng (W=4 defaults)
// against a sequence-table reference model.
module tb_lfsr_sng;

`ifdef LFSR_SNG_EN
  localparam bit SNG = 1'b1;
`else
  localparam bit SNG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] seed = 4'd0;
  logic [3:0] thr = 4'd0;
  logic [3:0] state;
  logic       q;
  logic       wrap;
  logic [3:0] period;
  logic       lockup;
  logic       sbit;

  lfsr_sng #(.W(4), .TAPS(4'b1100), .RESET_SEED(4'd1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed), .thr(thr),
    .state(state), .q(q), .wrap(wrap), .period(period), .lockup(lockup),
    .sbit(sbit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Maximal-length cycle for x^4+x^3+1 starting from 0001.
  int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  // Reference model state.
  int m_state, m_seedr, m_cnt, m_period, m_wrap, m_lock, m_sbit;

  function automatic int next_of(input int s);
    for (int i = 0; i < 15; i++)
      if (seq[i] == s) return seq[(i + 1) % 15];
    return 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic [3:0] sd, input logic [3:0] th);
    int nsbit;
    int ns;
    rst = r; load = l; en = e; seed = sd; thr = th;
    nsbit = SNG ? int'(m_state < int'(th)) : 0;
    if (r) begin
      m_state = 1; m_seedr = 1; m_cnt = 0; m_period = 0; m_wrap = 0;
      m_lock = 0; nsbit = 0;
    end else if (l) begin
      m_state = int'(sd); m_seedr = int'(sd); m_cnt = 0; m_wrap = 0; m_lock = 0;
    end else if (e) begin
      if (m_state == 0) begin
        m_state = 1; m_lock = 1; m_cnt = 0; m_wrap = 0;
      end else begin
        ns = next_of(m_state);
        m_state = ns;
        if (ns == m_seedr) begin
          m_wrap = 1; m_period = (m_cnt + 1) % 16; m_cnt = 0;
        end else begin
          m_wrap = 0; m_cnt = (m_cnt + 1) % 16;
        end
      end
    end else begin
      m_wrap = 0;
    end
    m_sbit = nsbit;
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("period", 32'(period), 32'(m_period));
    chk("lockup", 32'(lockup), 32'(m_lock));
    chk("sbit", 32'(sbit), 32'(m_sbit));
    chk("q", 32'(q), 32'((m_state == 0) ? 0 : (next_of(m_state) & 1)));
  endtask

  typedef struct {
    logic       rst, load, en;
    logic [3:0] seed;
    logic [3:0] e_state;
    logic       e_wrap;
    logic [3:0] e_period;
    logic       e_lock;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic e,
                              input logic [3:0] sd, input logic [3:0] es,
                              input logic ew, input logic [3:0] ep,
                              input logic el);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.seed = sd;
    v.e_state = es; v.e_wrap = ew; v.e_period = ep; v.e_lock = el;
    vecs.push_back(v);
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int steps;
    int ones;
    logic [3:0] ev [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    // Reset, then one full period from 0001.
    add(1, 0, 0, 4'd0, 4'd1, 0, 4'd0, 0);
    for (int i = 0; i < 15; i++)
      add(0, 0, 1, 4'd0, ev[i], (i == 14), (i == 14) ? 4'd15 : 4'd0, 0);
    add(0, 0, 1, 4'd0, 4'd2, 0, 4'd15, 0);
    // Seed reload and two steps.
    add(0, 1, 0, 4'd11, 4'd11, 0, 4'd15, 0);
    add(0, 0, 1, 4'd0, 4'd7, 0, 4'd15, 0);
    add(0, 0, 1, 4'd0, 4'd15, 0, 4'd15, 0);
    // Zero seed lock-up recovery; lockup is sticky.
    add(0, 1, 0, 4'd0, 4'd0, 0, 4'd15, 0);
    add(0, 0, 1, 4'd0, 4'd1, 0, 4'd15, 1);
    add(0, 0, 1, 4'd0, 4'd2, 0, 4'd15, 1);
    add(0, 0, 0, 4'd0, 4'd2, 0, 4'd15, 1);
    // Load beats en; then hold for five idle cycles.
    add(0, 1, 1, 4'd6, 4'd6, 0, 4'd15, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 4'd9, 4'd6, 0, 4'd15, 0);
    // Step to 1101, then reset overrides load and en.
    add(0, 0, 1, 4'd0, 4'd13, 0, 4'd15, 0);
    add(1, 1, 1, 4'd5, 4'd1, 0, 4'd0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].seed, 4'($urandom_range(0, 15)));
      chk("tbl_state", 32'(state), 32'(vecs[i].e_state));
      chk("tbl_wrap", 32'(wrap), 32'(vecs[i].e_wrap));
      chk("tbl_period", 32'(period), 32'(vecs[i].e_period));
      chk("tbl_lockup", 32'(lockup), 32'(vecs[i].e_lock));
    end
    chk("rst_sbit", 32'(sbit), 32'(0));

    // Seed 1011: wrap must fire on exactly the 15th step.
    cyc(0, 1, 0, 4'd11, 4'd0);
    steps = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 1, 4'd0, 4'd0);
      if (wrap) begin
        steps = k;
        break;
      end
    end
    chk("wrap_steps", 32'(steps), 32'(15));
    chk("wrap_state", 32'(state), 32'(11));
    chk("wrap_period", 32'(period), 32'(15));

    // SNG: thr=8 over one full period from 0001 gives 7 ones.
    cyc(1, 0, 0, 4'd0, 4'd8);
    ones = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 1, 4'd0, 4'd8);
      ones += int'(sbit);
    end
    chk("sng_thr8_ones", 32'(ones), 32'(SNG ? 7 : 0));
    cyc(0, 0, 1, 4'd0, 4'd0);
    ones = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 1, 4'd0, 4'd0);
      ones += int'(sbit);
    end
    chk("sng_thr0_ones", 32'(ones), 32'(0));

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 75), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
